pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
Parametrised elastic pipeline-register chain replacing the fixed IFID/IDEXE/EXEMEM/MEMWB-style latches. Carries a LEN-bit payload through DEPTH stages. Adds the following, none of which the fixed latches have:
- valid/ready handshake at both ends;
- global stall;
- per-stage flush for branch/hazard kill;
- bubble collapsing;
- occupancy and drop counters.

Parameters:
LEN, 32, payload width in bits.
DEPTH, 4, number of register stages; must be >= 1. Stage 0 is the input side; stage DEPTH-1 drives the output.
CNT_W, 16, width of the saturating drop counter.

Ports:
clock  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  freezes stage movement; flush still acts.
flush  input  DEPTH  bit i kills the item currently held in stage i.
in_valid  input  1  upstream offers in_data.
in_data  input  LEN  payload.
in_ready  output  1  chain accepts in_data this cycle.
out_valid  output  1  stage DEPTH-1 offers out_data.
out_data  output  LEN  payload of stage DEPTH-1.
out_ready  input  1  downstream takes out_data this cycle.
occupancy  output  clog2(DEPTH+1)  registered count of valid stages.
drop_count  output  CNT_W  saturating count of items discarded by flush.

Behaviour:
- Reset: synchronous, active-high; reset is fixed as synchronous, active-high on the single clock. It clears the following to 0 on the next edge, overriding every other input, including mid-transfer:
  - all valid_q[i] and data_q[i];
  - occupancy;
  - drop_count.
  Consequently, once reset has been sampled: in_ready=1, out_valid=0, out_data=0 (if stall=0).
- Per-stage state: valid_q[i], data_q[i].
- Effective valid: v[i] = valid_q[i] & ~flush[i]. Flushed items never advance and never appear at the output.
- Take signals:
  - take[DEPTH-1] = out_ready & ~stall.
  - take[i] = rdy[i+1] for i < DEPTH-1.
- Ready signals:
  - rdy[i] = ~stall & (~v[i] | take[i]).
  - in_ready = rdy[0]. This is combinational through the whole chain; there is no registered ready.
- Output:
  - out_valid = v[DEPTH-1] & ~stall (combinational mask).
  - out_data = data_q[DEPTH-1] regardless of valid.
- Stage update when rdy[i]=1:
  - valid_q[i] <= upstream valid, where upstream is v[i-1] for i > 0, or in_valid & ~flush[0] for i = 0.
  - data_q[i] <= upstream data. Data may load even when the valid being loaded is 0.
- Stage update when rdy[i]=0:
  - data_q[i] holds.
  - valid_q[i] <= v[i], so a flush clears the stage even under stall or backpressure.
- Flush of stage 0 while an input is accepted (in_valid & rdy[0] & flush[0]): the incoming item is consumed (handshake completes) and discarded.
- Bubble collapsing: an empty stage accepts from upstream even if downstream is blocked. Items compact toward the output.
- Latency and throughput: an item accepted at edge t, with no stalls, is presented on out_valid after edge t+DEPTH-1. Throughput is 1 item/cycle.
- Ordering: items leave in acceptance order; no reordering or duplication.
- occupancy: registered popcount of next-state valid_q. It lags valid_q by 0 cycles, i.e. it reflects state after the same edge.
- drop_count: increments per edge by popcount(valid_q & flush) plus (in_valid & rdy[0] & flush[0]). Saturates at 2^CNT_W-1; no wrap.
- DEPTH=1: degenerates to a single skid-less register with the same rules.

Test Plan:
1. Streaming (DEPTH=4): after reset, out_ready=1, push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles -> out_valid rises 3 edges after first accept; out_data 0x11..0x55 on consecutive cycles; in_ready stays 1; occupancy peaks at 4.
2. Backpressure: out_ready=0, in_valid=1 with 0xA0..0xA5 -> exactly 4 accepted, in_ready=0 on the 5th offer, occupancy=4. Then raise out_ready -> in_ready=1 in the same cycle; outputs 0xA0..0xA5 in order, none lost.
3. Bubble collapse: out_ready=0, push 0x01 alone, idle 3 cycles, push 0x02 -> 0x01 in stage 3 and 0x02 in stage 2 after 2 more edges; occupancy=2.
4. Flush: stages 0..3 hold 0x10,0x20,0x30,0x40 (stage 3 = 0x40), out_ready=0, flush=4'b0011 for one cycle -> 0x20,0x10 dropped, drop_count=2, occupancy=2; with out_ready=1, output is 0x40 then 0x30 only.
5. Stall + flush: full chain, stall=1 for 3 cycles with flush=4'b1000 in the second -> out_valid=0 and in_ready=0 throughout; only stage 3 cleared, drop_count +1; after stall drops, the remaining 3 items emerge in order.
6. Reset / saturation: CNT_W=2, flush 5 items total -> drop_count sticks at 3. Assert reset mid-stream with the chain full -> after one edge occupancy=0, out_valid=0, drop_count=0, in_ready=1.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Elastic DEPTH-stage register chain: valid/ready at both ends, global stall,
// per-stage flush, bubble collapsing, occupancy and saturating drop counters.
module pipe_stage_chain #(
    parameter int LEN   = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [DEPTH-1:0]             flush,
    input  logic                         in_valid,
    input  logic [LEN-1:0]               in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [LEN-1:0]               out_data,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_W-1:0]             drop_count
);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int INC_W = $clog2(DEPTH + 2);
    localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] up_v;
    logic [DEPTH:0]   rdy_chain;
    logic [LEN-1:0]   data_q [DEPTH];
    logic [LEN-1:0]   data_d [DEPTH];
    logic [LEN-1:0]   up_d   [DEPTH];
    logic [OCC_W-1:0] occupancy_q;
    logic [OCC_W-1:0] occupancy_d;
    logic [CNT_W-1:0] drop_q;
    logic [CNT_W-1:0] drop_d;
    logic [INC_W-1:0] drop_inc;
    logic [SUM_W-1:0] drop_sum;

    assign v = valid_q & ~flush;

    // Ready ripples from the output back to the input in one cycle; the extra
    // top bit of the chain stands for the downstream consumer.
    always_comb begin
        rdy_chain        = '0;
        rdy_chain[DEPTH] = out_ready & ~stall;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_chain[i] = ~stall & (~v[i] | rdy_chain[i+1]);
        end
    end
    assign rdy = rdy_chain[DEPTH-1:0];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_v[gi] = in_valid & ~flush[0];
                assign up_d[gi] = in_data;
            end else begin : g_body
                assign up_v[gi] = v[gi-1];
                assign up_d[gi] = data_q[gi-1];
            end
            // A blocked stage still drops its valid when flushed.
            assign valid_d[gi] = rdy[gi] ? up_v[gi] : v[gi];
            assign data_d[gi]  = rdy[gi] ? up_d[gi] : data_q[gi];
        end
    endgenerate

    always_comb begin
        occupancy_d = '0;
        drop_inc    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
            drop_inc    = drop_inc + INC_W'(valid_q[i] & flush[i]);
        end
        drop_inc = drop_inc + INC_W'(in_valid & rdy[0] & flush[0]);
        drop_sum = SUM_W'(drop_q) + SUM_W'(drop_inc);
        drop_d   = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            drop_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            drop_q      <= drop_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready   = rdy[0];
    assign out_valid  = v[DEPTH-1] & ~stall;
    assign out_data   = data_q[DEPTH-1];
    assign occupancy  = occupancy_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus a random
// run against a slot-sweep reference model of the chain.
module tb_pipe_stage_chain;
    localparam int LEN      = 32;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 2;
    localparam int OCC_W    = 3;
    localparam int DROP_MAX = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset, stall, in_valid, out_ready;
    logic [DEPTH-1:0] flush;
    logic [LEN-1:0]   in_data;
    logic             in_ready, out_valid;
    logic [LEN-1:0]   out_data;
    logic [OCC_W-1:0] occupancy;
    logic [CNT_W-1:0] drop_count;

    pipe_stage_chain #(.LEN(LEN), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .occupancy(occupancy), .drop_count(drop_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: slot contents, swept from the output end each cycle.
    bit             m_full [DEPTH];
    logic [LEN-1:0] m_item [DEPTH];
    int             m_drop = 0;

    logic             e_in_ready, e_out_valid;
    logic [LEN-1:0]   e_out_data;
    logic [OCC_W-1:0] e_occ;
    logic [CNT_W-1:0] e_drop;

    logic             s_in_ready, s_out_valid;
    logic [LEN-1:0]   s_out_data;
    logic [OCC_W-1:0] s_occ;
    logic [CNT_W-1:0] s_drop;

    task automatic model_step(input logic rst, input logic iv, input logic [LEN-1:0] id,
                              input logic ordy, input logic st, input logic [DEPTH-1:0] fl);
        int dropped = 0;
        int cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_full[i] && fl[i]) begin
                m_full[i] = 1'b0;
                dropped++;
            end
        end
        e_out_valid = m_full[DEPTH-1] && !st;
        e_out_data  = m_item[DEPTH-1];
        e_in_ready  = 1'b0;
        if (!st) begin
            if (m_full[DEPTH-1] && ordy) m_full[DEPTH-1] = 1'b0;
            for (int i = DEPTH - 1; i >= 1; i--) begin
                if (!m_full[i] && m_full[i-1]) begin
                    m_full[i]   = 1'b1;
                    m_item[i]   = m_item[i-1];
                    m_full[i-1] = 1'b0;
                end
            end
            e_in_ready = !m_full[0];
            if (iv && e_in_ready) begin
                if (fl[0]) dropped++;
                else begin
                    m_full[0] = 1'b1;
                    m_item[0] = id;
                end
            end
        end
        m_drop = (m_drop + dropped > DROP_MAX) ? DROP_MAX : m_drop + dropped;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_full[i] = 1'b0;
            m_drop = 0;
        end
        for (int i = 0; i < DEPTH; i++) cnt += int'(m_full[i]);
        e_occ  = OCC_W'(cnt);
        e_drop = CNT_W'(m_drop);
    endtask

    // One clock: drive at negedge, sample combinational outputs, clock, sample registers.
    task automatic tick(input logic rst, input logic iv, input logic [LEN-1:0] id,
                        input logic ordy, input logic st, input logic [DEPTH-1:0] fl);
        reset = rst; in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
        #1;
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out_data  = out_data;
        model_step(rst, iv, id, ordy, st, fl);
        @(posedge clock);
        #1;
        s_occ  = occupancy;
        s_drop = drop_count;
        @(negedge clock);
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic fill4(input logic [LEN-1:0] base);
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, base + LEN'(k), 1'b0, 1'b0, '0);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0, '0);
        n_checks++; if (s_occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", s_occ); end
        n_checks++; if (s_drop !== 2'd0) begin n_fail++; $display("FAIL reset_drop got=%0d exp=0", s_drop); end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", s_in_ready); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", s_out_valid); end
        n_checks++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", s_out_data); end
    endtask

    task automatic test_streaming();
        logic [OCC_W-1:0] max_occ = '0;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick(1'b0, k < 5, 32'(32'h11 * (k + 1)), 1'b1, 1'b0, '0);
            n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, s_in_ready); end
            n_checks++; if (s_out_valid !== (k >= 4 && k <= 8)) begin n_fail++; $display("FAIL stream_out_valid k=%0d got=%b exp=%b", k, s_out_valid, (k >= 4 && k <= 8)); end
            if (k >= 4 && k <= 8) begin
                n_checks++; if (s_out_data !== 32'(32'h11 * (k - 3))) begin n_fail++; $display("FAIL stream_out_data k=%0d got=%h exp=%h", k, s_out_data, 32'(32'h11 * (k - 3))); end
            end
            n_checks++; if (s_occ !== e_occ) begin n_fail++; $display("FAIL stream_occ k=%0d got=%0d exp=%0d", k, s_occ, e_occ); end
            if (s_occ > max_occ) max_occ = s_occ;
        end
        n_checks++; if (max_occ !== 3'd4) begin n_fail++; $display("FAIL stream_peak_occ got=%0d exp=4", max_occ); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 32'hA0 + LEN'(sent), 1'b0, 1'b0, '0);
            n_checks++; if (s_in_ready !== (k < 4)) begin n_fail++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, s_in_ready, (k < 4)); end
            if (s_in_ready === 1'b1) sent++;
        end
        n_checks++; if (s_occ !== 3'd4) begin n_fail++; $display("FAIL bp_occ got=%0d exp=4", s_occ); end
        for (int k = 0; k < 20 && got < 6; k++) begin
            tick(1'b0, sent < 6, 32'hA0 + LEN'(sent), 1'b1, 1'b0, '0);
            if (k == 0) begin
                n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", s_in_ready); end
            end
            if (sent < 6 && s_in_ready === 1'b1) sent++;
            if (s_out_valid === 1'b1) begin
                n_checks++; if (s_out_data !== 32'hA0 + LEN'(got)) begin n_fail++; $display("FAIL bp_order got=%h exp=%h", s_out_data, 32'hA0 + LEN'(got)); end
                got++;
            end
        end
        n_checks++; if (got !== 6) begin n_fail++; $display("FAIL bp_count got=%0d exp=6", got); end
    endtask

    task automatic test_bubble_collapse();
        do_reset();
        tick(1'b0, 1'b1, 32'h01, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 32'h02, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (s_occ !== 3'd2) begin n_fail++; $display("FAIL bubble_occ got=%0d exp=2", s_occ); end
        n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h01) begin n_fail++; $display("FAIL bubble_head got=%b/%h exp=1/01", s_out_valid, s_out_data); end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h01) begin n_fail++; $display("FAIL bubble_out1 got=%b/%h exp=1/01", s_out_valid, s_out_data); end
        tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
        n_checks++; if (s_out_valid !== 1'b1 || s_out_data !== 32'h02) begin n_fail++; $display("FAIL bubble_out2 got=%b/%h exp=1/02", s_out_valid, s_out_data); end
        n_checks++; if (s_occ !== 3'd0) begin n_fail++; $display("FAIL bubble_drain_occ got=%0d exp=0", s_occ); end
    endtask

    task automatic test_flush();
        logic [LEN-1:0] exp_seq [3];
        exp_seq[0] = 32'h40; exp_seq[1] = 32'h30; exp_seq[2] = 32'h0;
        do_reset();
        for (int k = 0; k < 4; k++) tick(1'b0, 1'b1, 32'(32'h40 - 32'h10 * k), 1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, 4'b0011);
        n_checks++; if (s_drop !== 2'd2) begin n_fail++; $display("FAIL flush_drop got=%0d exp=2", s_drop); end
        n_checks++; if (s_occ !== 3'd2) begin n_fail++; $display("FAIL flush_occ got=%0d exp=2", s_occ); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
            n_checks++; if (s_out_valid !== (k < 2)) begin n_fail++; $display("FAIL flush_out_valid k=%0d got=%b exp=%b", k, s_out_valid, (k < 2)); end
            if (k < 2) begin
                n_checks++; if (s_out_data !== exp_seq[k]) begin n_fail++; $display("FAIL flush_out_data k=%0d got=%h exp=%h", k, s_out_data, exp_seq[k]); end
            end
        end
    endtask

    task automatic test_stall_flush();
        int got = 0;
        do_reset();
        fill4(32'h50);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b1, 32'h99, 1'b1, 1'b1, (k == 1) ? 4'b1000 : 4'b0000);
            n_checks++; if (s_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready k=%0d got=%b exp=0", k, s_in_ready); end
            n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_out_valid k=%0d got=%b exp=0", k, s_out_valid); end
        end
        n_checks++; if (s_drop !== 2'd1) begin n_fail++; $display("FAIL stall_drop got=%0d exp=1", s_drop); end
        n_checks++; if (s_occ !== 3'd3) begin n_fail++; $display("FAIL stall_occ got=%0d exp=3", s_occ); end
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
            if (s_out_valid === 1'b1) begin
                n_checks++; if (s_out_data !== 32'h51 + LEN'(got)) begin n_fail++; $display("FAIL stall_order got=%h exp=%h", s_out_data, 32'h51 + LEN'(got)); end
                got++;
            end
        end
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL stall_count got=%0d exp=3", got); end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'b1, 32'h70 + LEN'(k), 1'b1, 1'b0, 4'b0001);
            n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_in_ready k=%0d got=%b exp=1", k, s_in_ready); end
            n_checks++; if (s_drop !== 2'((k + 1 > 3) ? 3 : k + 1)) begin n_fail++; $display("FAIL sat_drop k=%0d got=%0d exp=%0d", k, s_drop, (k + 1 > 3) ? 3 : k + 1); end
        end
        fill4(32'h80);
        n_checks++; if (s_occ !== 3'd4) begin n_fail++; $display("FAIL sat_full_occ got=%0d exp=4", s_occ); end
        tick(1'b1, 1'b1, 32'hEE, 1'b1, 1'b0, '0);
        n_checks++; if (s_occ !== 3'd0) begin n_fail++; $display("FAIL midreset_occ got=%0d exp=0", s_occ); end
        n_checks++; if (s_drop !== 2'd0) begin n_fail++; $display("FAIL midreset_drop got=%0d exp=0", s_drop); end
        tick(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        n_checks++; if (s_in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready got=%b exp=1", s_in_ready); end
        n_checks++; if (s_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid got=%b exp=0", s_out_valid); end
        n_checks++; if (s_out_data !== 32'h0) begin n_fail++; $display("FAIL midreset_out_data got=%h exp=0", s_out_data); end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic             rst  = ($urandom_range(0, 99) == 0);
            logic             iv   = ($urandom_range(0, 3) != 0);
            logic             ordy = ($urandom_range(0, 2) != 0);
            logic             st   = ($urandom_range(0, 4) == 0);
            logic [DEPTH-1:0] fl   = ($urandom_range(0, 5) == 0) ? DEPTH'($urandom) : '0;
            tick(rst, iv, LEN'($urandom), ordy, st, fl);
            n_checks++; if (s_in_ready !== e_in_ready) begin n_fail++; $display("FAIL rand_in_ready k=%0d got=%b exp=%b", k, s_in_ready, e_in_ready); end
            n_checks++; if (s_out_valid !== e_out_valid) begin n_fail++; $display("FAIL rand_out_valid k=%0d got=%b exp=%b", k, s_out_valid, e_out_valid); end
            if (e_out_valid) begin
                n_checks++; if (s_out_data !== e_out_data) begin n_fail++; $display("FAIL rand_out_data k=%0d got=%h exp=%h", k, s_out_data, e_out_data); end
            end
            n_checks++; if (s_occ !== e_occ) begin n_fail++; $display("FAIL rand_occ k=%0d got=%0d exp=%0d", k, s_occ, e_occ); end
            n_checks++; if (s_drop !== e_drop) begin n_fail++; $display("FAIL rand_drop k=%0d got=%0d exp=%0d", k, s_drop, e_drop); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_full[i] = 1'b0;
            m_item[i] = '0;
        end
        reset = 1'b1; stall = 1'b0; flush = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clock);
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_stall_flush();
        test_saturation_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
